// File: rtl/led_scan_bcd_if.sv
// rtl/led_scan_bcd_if.sv - load/busy handshake and display bus for led_scan_bcd
//
// Signals:
//   bin_in   : 14-bit binary value, sampled on an accepted load
//   load     : conversion request, accepted only while busy = 0
//   blank_lz : 1 = suppress leading zeros
//   busy     : conversion in progress
//   ovf      : last accepted value exceeded 9999 and was saturated
//   num      : BCD code of the selected digit
//   dig_sel  : one-cold digit enable, digit 0 = ones
// Modports: master drives the request side, slave is the converter/scanner.

interface led_scan_bcd_if;
    logic [13:0] bin_in;
    logic        load;
    logic        blank_lz;
    logic        busy;
    logic        ovf;
    logic [3:0]  num;
    logic [3:0]  dig_sel;

    modport master (
        output bin_in, load, blank_lz,
        input  busy, ovf, num, dig_sel
    );

    modport slave (
        input  bin_in, load, blank_lz,
        output busy, ovf, num, dig_sel
    );
endinterface

// File: rtl/led_scan_bcd.sv
// rtl/led_scan_bcd.sv - binary to BCD converter with 4-digit multiplexed display scanner
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : led_scan_bcd_if.slave (bin_in, load, blank_lz in; busy, ovf, num, dig_sel out)
// Parameter:
//   SCAN_DIV : clock cycles each digit stays selected (>= 2)

module led_scan_bcd #(
    parameter int SCAN_DIV = 50000
) (
    input  logic           clk,
    input  logic           rst_n,
    led_scan_bcd_if.slave  bus
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] sreg_q, sreg_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [15:0] digits_q, digits_d;
    logic        ovf_q, ovf_d;
    logic [15:0] adj;

    logic [DW-1:0] div_q;
    logic [1:0]    idx_q;

    logic        over;
    logic [13:0] sat;

    assign over = (bus.bin_in > 14'd9999);
    assign sat  = over ? 14'd9999 : bus.bin_in;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    state_d = CONV;
                    sreg_d  = sat;
                    pend_d  = over;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                acc_d  = {adj[14:0], sreg_q[13]};
                sreg_d = {sreg_q[12:0], 1'b0};
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    // Digits and ovf are committed together so the scanner
                    // never sees a half-converted value.
                    state_d  = IDLE;
                    digits_d = {adj[14:0], sreg_q[13]};
                    ovf_d    = pend_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running scanner, independent of the conversion FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= 2'd0;
        end else if (div_q == DIV_MAX) begin
            div_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    logic [3:0] cur;
    logic       blank;

    always_comb begin
        cur   = 4'd0;
        blank = 1'b0;
        unique case (idx_q)
            2'd0: begin
                cur   = digits_q[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                cur   = digits_q[7:4];
                blank = (digits_q[15:4] == 12'd0);
            end
            2'd2: begin
                cur   = digits_q[11:8];
                blank = (digits_q[15:8] == 8'd0);
            end
            2'd3: begin
                cur   = digits_q[15:12];
                blank = (digits_q[15:12] == 4'd0);
            end
            default: begin
                cur   = 4'd0;
                blank = 1'b0;
            end
        endcase
    end

    // A blanked digit still drives num (it is 0 by construction).
    assign bus.num     = cur;
    assign bus.dig_sel = (bus.blank_lz && blank) ? 4'b1111 : ~(4'b0001 << idx_q);
    assign bus.busy    = (state_q == CONV);
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_led_scan_bcd.sv
// tb/tb_led_scan_bcd.sv - self-checking bench for led_scan_bcd

module tb_led_scan_bcd;

    localparam int SCAN_DIV = 4;

    logic clk;
    logic rst_n;
    led_scan_bcd_if bus ();

    led_scan_bcd #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Reference state: the value on display, its overflow flag, and the
    // number of clock edges since reset (which fixes the scan position).
    int model_val;
    int model_ovf;
    int edges;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    task automatic check_display(input string tag);
        int pos, digit, nsig, sel;
        pos   = (edges / SCAN_DIV) % 4;
        digit = (model_val / pow10(pos)) % 10;
        nsig  = (model_val >= 1000) ? 4 : (model_val >= 100) ? 3 : (model_val >= 10) ? 2 : 1;
        if (bus.blank_lz && pos >= nsig) sel = 15;
        else                             sel = 15 - (1 << pos);
        chk({tag, "_num"}, int'(bus.num), digit);
        chk({tag, "_sel"}, int'(bus.dig_sel), sel);
        chk({tag, "_ovf"}, int'(bus.ovf), model_ovf);
    endtask

    task automatic scan(input string tag, input int n, input bit rnd_blank);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rnd_blank) bus.blank_lz = 1'($urandom_range(0, 1));
            #1;
            check_display(tag);
        end
    endtask

    // Starts a conversion of v, optionally pokes a second load during busy
    // (inj_at) or resets mid-conversion (rst_at), and checks the outcome.
    task automatic run_conv(input int v, input int inj_at, input int rst_at);
        int cnt;
        bus.load   = 1'b1;
        bus.bin_in = 14'(v);
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        chk("busy_rise", int'(bus.busy), 1);
        cnt = 1;
        while (bus.busy && cnt < 40) begin
            if (cnt == inj_at) begin
                bus.load   = 1'b1;
                bus.bin_in = 14'd1111;
            end
            if (cnt == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", int'(bus.busy), 0);
                chk("rst_ovf",  int'(bus.ovf), 0);
                chk("rst_num",  int'(bus.num), 0);
                chk("rst_sel",  int'(bus.dig_sel), 4'b1110);
                model_val = 0;
                model_ovf = 0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
            bus.load = 1'b0;
            if (bus.busy) cnt++;
        end
        chk("busy_len", cnt, 14);
        model_val = (v > 9999) ? 9999 : v;
        model_ovf = (v > 9999) ? 1 : 0;
        check_display("post_conv");
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        model_val   = 0;
        model_ovf   = 0;
        rst_n       = 1'b0;
        bus.load    = 1'b0;
        bus.bin_in  = '0;
        bus.blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(bus.busy), 0);
        check_display("reset");
        rst_n = 1'b1;
        scan("idle0", 6, 1'b0);

        // Basic conversion and a full scan frame plus wrap.
        run_conv(1234, -1, -1);
        scan("b1234", 20, 1'b0);

        // Saturation, then back to zero.
        run_conv(12000, -1, -1);
        scan("sat", 16, 1'b0);
        run_conv(0, -1, -1);
        scan("zero", 16, 1'b0);

        // Blanking.
        bus.blank_lz = 1'b1;
        run_conv(7, -1, -1);
        scan("bl7", 16, 1'b0);
        bus.blank_lz = 1'b0;
        scan("nb7", 16, 1'b0);
        bus.blank_lz = 1'b1;
        run_conv(9001, -1, -1);
        scan("bl9001", 16, 1'b0);

        // Handshake: a load during busy is ignored; one right after is taken.
        bus.blank_lz = 1'b0;
        run_conv(5678, 3, -1);
        chk("hs_load_low", int'(bus.load), 0);
        scan("hs5678", 8, 1'b0);
        run_conv(1111, -1, -1);
        scan("hs1111", 8, 1'b0);

        // Mid-conversion reset, then a clean reconversion.
        run_conv(4321, -1, 7);
        scan("after_rst", 16, 1'b0);
        run_conv(4321, -1, -1);
        scan("r4321", 16, 1'b0);

        // Randomized values with random blanking changes.
        for (int n = 0; n < 25; n++) begin
            int v;
            v = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 120));
            bus.blank_lz = 1'($urandom_range(0, 1));
            run_conv(v, (n % 5 == 0) ? int'($urandom_range(1, 13)) : -1, -1);
            scan("rnd", int'($urandom_range(1, 20)), 1'b1);
        end

        // Reset asserted mid-frame while idle.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst2_busy", int'(bus.busy), 0);
        chk("rst2_ovf",  int'(bus.ovf), 0);
        chk("rst2_num",  int'(bus.num), 0);
        chk("rst2_sel",  int'(bus.dig_sel), 4'b1110);
        model_val = 0;
        model_ovf = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.blank_lz = 1'b0;
        scan("post_rst2", 8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
